// File: rtl/interp_read_scheduler.sv
// Two-requester round-robin read scheduler with an in-order tag FIFO that
// steers returned pixel pairs to the interpolator and routes results back by requester id.
// Optional STALL_COUNTER_EN: counts IDLE cycles where a request is blocked by a full tag FIFO.
module interp_read_scheduler #(
  parameter int ADDR_W    = 20,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [1:0]        req0_frac,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [1:0]        req1_frac,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  input  logic [15:0]       mem_rd_data,
  input  logic              mem_rd_data_valid,
  output logic [15:0]       interp_pixel,
  output logic [1:0]        interp_fraction,
  output logic              interp_valid,
  input  logic [7:0]        interp_result,
  input  logic              interp_result_valid,
  output logic [7:0]        out_pixel,
  output logic              out_valid,
  output logic              out_src,
  output logic              error_underflow,
  output logic [31:0]       stall_count
);
  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;

  logic              rst_d;
  logic              last_q;
  logic              capture, grant_id, any_req;
  logic              full, empty, pop, can_push;
  logic [ADDR_W-1:0] addr_q;
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [2:0]        tag_mem [TAG_DEPTH];
  logic [2:0]        tag_wr, tag_rd;

  logic [15:0] interp_pixel_q;
  logic [1:0]  interp_fraction_q;
  logic        interp_valid_q;
  logic        src_d1, src_d2;
  logic [7:0]  out_pixel_q;
  logic        out_valid_q, out_src_q, err_q;

  // The HOLD request already owns a FIFO slot, so occupancy equals outstanding reads.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop      = mem_rd_data_valid && !empty;
  assign can_push = !full || pop;
  assign any_req  = req0_valid || req1_valid;
  assign grant_id = (req0_valid && req1_valid) ? !last_q : req1_valid;
  assign tag_wr   = grant_id ? {req1_frac, 1'b1} : {req0_frac, 1'b0};
  assign tag_rd   = tag_mem[rd_ptr[PTR_W-1:0]];

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset && !rst_d && any_req && can_push) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (mem_rd_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rst_d   <= 1'b1;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      rst_d   <= 1'b0;
      if (capture) begin
        last_q <= grant_id;
        addr_q <= grant_id ? req1_addr : req0_addr;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) tag_mem[wr_ptr[PTR_W-1:0]] <= tag_wr;
  end

  // src rides two stages so it lines up with the interpolator's registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      interp_pixel_q    <= '0;
      interp_fraction_q <= '0;
      interp_valid_q    <= 1'b0;
      src_d1            <= 1'b0;
      src_d2            <= 1'b0;
      out_pixel_q       <= '0;
      out_valid_q       <= 1'b0;
      out_src_q         <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      interp_valid_q <= pop;
      if (pop) begin
        interp_pixel_q    <= mem_rd_data;
        interp_fraction_q <= tag_rd[2:1];
        src_d1            <= tag_rd[0];
      end
      src_d2      <= src_d1;
      out_pixel_q <= interp_result;
      out_valid_q <= interp_result_valid;
      out_src_q   <= src_d2;
      if (mem_rd_data_valid && empty) err_q <= 1'b1;
    end
  end

  assign req0_ready      = capture && !grant_id;
  assign req1_ready      = capture && grant_id;
  assign mem_rd_valid    = (state_q == HOLD) && !reset;
  assign mem_rd_addr     = reset ? '0 : addr_q;
  assign interp_pixel    = reset ? '0 : interp_pixel_q;
  assign interp_fraction = reset ? '0 : interp_fraction_q;
  assign interp_valid    = interp_valid_q && !reset;
  assign out_pixel       = reset ? '0 : out_pixel_q;
  assign out_valid       = out_valid_q && !reset;
  assign out_src         = out_src_q && !reset;
  assign error_underflow = err_q && !reset;

`ifdef STALL_COUNTER_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == IDLE && any_req && full && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_count = reset ? '0 : stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_interp_read_scheduler.sv
// Randomized bench for interp_read_scheduler with a queue-based reference model
// and a 1-cycle interpolator stand-in; directed phases cover the corner cases.
module tb_interp_read_scheduler;
  localparam int ADDR_W = 20;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] req0_addr, req1_addr, mem_rd_addr;
  logic [1:0]        req0_frac, req1_frac, interp_fraction;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic              mem_rd_valid, mem_rd_ready, mem_rd_data_valid;
  logic [15:0]       mem_rd_data, interp_pixel;
  logic              interp_valid, interp_result_valid;
  logic [7:0]        interp_result, out_pixel;
  logic              out_valid, out_src, error_underflow;
  logic [31:0]       stall_count;

  interp_read_scheduler #(.ADDR_W(ADDR_W), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_addr(req0_addr), .req0_frac(req0_frac), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_addr(req1_addr), .req1_frac(req1_frac), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
    .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
    .interp_pixel(interp_pixel), .interp_fraction(interp_fraction), .interp_valid(interp_valid),
    .interp_result(interp_result), .interp_result_valid(interp_result_valid),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_src(out_src),
    .error_underflow(error_underflow), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] interp_fn(input logic [15:0] p, input logic [1:0] f);
    int r;
    r = (int'(p[7:0]) * (4 - int'(f)) + int'(p[15:8]) * int'(f)) / 4;
    return r[7:0];
  endfunction

  // Interpolator stand-in with one cycle of latency.
  always @(posedge clk) begin
    if (reset) begin
      interp_result       <= '0;
      interp_result_valid <= 1'b0;
    end else begin
      interp_result       <= interp_fn(interp_pixel, interp_fraction);
      interp_result_valid <= interp_valid;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  bit                busy, last_g, rst_prev, exp_err, last_seen;
  logic [ADDR_W-1:0] busy_addr;
  bit [2:0]          tagq[$];
  bit                ov_vld[3];
  bit [15:0]         ov_pix[3];
  bit [1:0]          ov_frac[3];
  bit                ov_src[3];
  logic [31:0]       exp_stall;
  int                mem_out, acc_cnt;

  // Called with inputs applied just after a rising edge; checks, updates model, advances one cycle.
  task automatic tick();
    bit win, g, e0, e1, can;
    bit [2:0] t;
    #1;
    win = reset || rst_prev;
    g   = (req0_valid && req1_valid) ? !last_g : req1_valid;
    can = !busy && (tagq.size() < DEPTH || (mem_rd_data_valid && tagq.size() > 0));
    e0  = !win && can && req0_valid && !g;
    e1  = !win && can && req1_valid && g;
    if (win) begin
      chk("rst_zero", 64'({req0_ready, req1_ready, mem_rd_valid, mem_rd_addr, interp_pixel,
                           interp_fraction, interp_valid, out_pixel, out_valid, out_src,
                           error_underflow}), 64'd0);
      chk("rst_stall", 64'(stall_count), 64'd0);
    end else begin
      chk("req_rdy", 64'({req1_ready, req0_ready}), 64'({e1, e0}));
      chk("mem_vld", 64'(mem_rd_valid), 64'(busy));
      if (busy) chk("mem_addr", 64'(mem_rd_addr), 64'(busy_addr));
      chk("ivld", 64'(interp_valid), 64'(ov_vld[0]));
      if (ov_vld[0]) chk("ipix", 64'({interp_pixel, interp_fraction}), 64'({ov_pix[0], ov_frac[0]}));
      chk("ovld", 64'(out_valid), 64'(ov_vld[2]));
      if (ov_vld[2]) chk("opix", 64'({out_src, out_pixel}),
                         64'({ov_src[2], interp_fn(ov_pix[2], ov_frac[2])}));
      chk("err", 64'(error_underflow), 64'(exp_err));
      chk("stall", 64'(stall_count), 64'(exp_stall));
    end
    if (req0_ready || req1_ready) begin
      acc_cnt++;
      last_seen = req1_ready;
    end
    if (reset) begin
      busy = 0; last_g = 1; exp_err = 0; exp_stall = '0; mem_out = 0;
      tagq.delete();
      for (int i = 0; i < 3; i++) ov_vld[i] = 0;
    end else begin
`ifdef STALL_COUNTER_EN
      if (!busy && (req0_valid || req1_valid) && tagq.size() == DEPTH && exp_stall != 32'hFFFF_FFFF)
        exp_stall = exp_stall + 32'd1;
`endif
      for (int i = 2; i > 0; i--) begin
        ov_vld[i] = ov_vld[i-1]; ov_pix[i] = ov_pix[i-1];
        ov_frac[i] = ov_frac[i-1]; ov_src[i] = ov_src[i-1];
      end
      ov_vld[0] = 0;
      if (mem_rd_data_valid) begin
        if (tagq.size() > 0) begin
          t = tagq.pop_front();
          ov_vld[0] = 1; ov_pix[0] = mem_rd_data; ov_frac[0] = t[2:1]; ov_src[0] = t[0];
          if (mem_out > 0) mem_out--;
        end else begin
          exp_err = 1;
        end
      end
      if (busy && mem_rd_ready) begin
        busy = 0;
        mem_out++;
      end
      if (e0 || e1) begin
        tagq.push_back(e1 ? {req1_frac, 1'b1} : {req0_frac, 1'b0});
        busy      = 1;
        busy_addr = e1 ? req1_addr : req0_addr;
        last_g    = e1;
      end
    end
    rst_prev = reset;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; mem_rd_ready = 1; mem_rd_data_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); tick();
    reset = 0;
  endtask

  task automatic rand_inputs(input int ret_pct);
    req0_valid = ($urandom_range(0, 99) < 60); req0_addr = ADDR_W'($urandom); req0_frac = 2'($urandom);
    req1_valid = ($urandom_range(0, 99) < 60); req1_addr = ADDR_W'($urandom); req1_frac = 2'($urandom);
    mem_rd_ready      = ($urandom_range(0, 99) < 70);
    mem_rd_data_valid = (mem_out > 0) && ($urandom_range(0, 99) < ret_pct);
    mem_rd_data       = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    req0_valid = 0; req1_valid = 0; mem_rd_ready = 1;
    while ((mem_out > 0 || busy || tagq.size() > 0) && n < 300) begin
      mem_rd_data_valid = (mem_out > 0);
      mem_rd_data = 16'($urandom);
      tick();
      n++;
    end
    mem_rd_data_valid = 0;
    chk("drain_bound", 64'(n < 300), 64'd1);
    repeat (4) tick();
  endtask

  task automatic wait_acc(input string tag);
    int a0 = acc_cnt;
    int n = 0;
    while (acc_cnt == a0 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 64'(acc_cnt != a0), 64'd1);
  endtask

  initial begin
    int n, a0;
    logic [3:0] seq;
    reset = 1; rst_prev = 1; last_g = 1;
    req0_addr = '0; req1_addr = '0; req0_frac = '0; req1_frac = '0;
    mem_rd_data = '0;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();

    // Single request from req0, data 0x4020, fraction 2.
    req0_valid = 1; req0_addr = 20'h00010; req0_frac = 2'd2;
    wait_acc("d_accept");
    req0_valid = 0;
    tick();
    mem_rd_data_valid = 1; mem_rd_data = 16'h4020;
    tick();
    mem_rd_data_valid = 0;
    n = 0;
    while (!interp_valid && n < 10) begin tick(); n++; end
    chk("d_ipix", 64'({interp_pixel, interp_fraction}), 64'({16'h4020, 2'd2}));
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    chk("d_out", 64'({out_valid, out_src, out_pixel}), 64'({1'b1, 1'b0, 8'h30}));
    drain();

    // Both requesters valid continuously: grants alternate starting with req0.
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_frac = 2'd1; req1_frac = 2'd3;
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      wait_acc("rr_accept");
      seq[3-k] = last_seen;
    end
    chk("rr_seq", 64'(seq), 64'(4'b0101));
    drain();

    // Memory stalls in HOLD while req1 toggles: address held, no new grants.
    req0_valid = 1; req0_addr = 20'hABCDE; req0_frac = 2'd0;
    wait_acc("hold_accept");
    req0_valid = 0; mem_rd_ready = 0;
    a0 = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      req1_valid = k[0]; req1_addr = ADDR_W'($urandom);
      tick();
      chk("hold_addr", 64'({mem_rd_valid, mem_rd_addr}), 64'({1'b1, 20'hABCDE}));
    end
    chk("hold_rdy", 64'(acc_cnt - a0), 64'd0);
    req1_valid = 0; mem_rd_ready = 1;
    drain();

    // Capacity: no returns, exactly DEPTH reads accepted; one return frees one slot.
    a0 = acc_cnt;
    req0_valid = 1; req1_valid = 1;
    repeat (40) tick();
    chk("full_accepts", 64'(acc_cnt - a0), 64'(DEPTH));
`ifdef STALL_COUNTER_EN
    chk("stall_inc", 64'(stall_count >= 32'd20), 64'd1);
`else
    chk("stall_off", 64'(stall_count), 64'd0);
`endif
    a0 = acc_cnt;
    mem_rd_data_valid = 1; mem_rd_data = 16'h1234;
    tick();
    mem_rd_data_valid = 0;
    repeat (10) tick();
    chk("slot_freed", 64'(acc_cnt - a0), 64'd1);
    drain();

    // Reset with three reads outstanding, then a stale return underflows.
    req0_valid = 1; req1_valid = 1; mem_rd_ready = 1;
    n = 0;
    while (tagq.size() < 3 && n < 30) begin tick(); n++; end
    chk("three_out", 64'(tagq.size()), 64'd3);
    do_reset();
    tick();
    mem_rd_data_valid = 1; mem_rd_data = 16'hBEEF;
    tick();
    mem_rd_data_valid = 0;
    tick();
    chk("uflow", 64'({error_underflow, interp_valid}), 64'({1'b1, 1'b0}));
    repeat (3) tick();
    chk("uflow_sticky", 64'(error_underflow), 64'd1);
    do_reset();
    tick();
    chk("uflow_clr", 64'(error_underflow), 64'd0);
    req0_valid = 1; req1_valid = 1;
    wait_acc("post_rst_acc");
    chk("post_rst_first", 64'(last_seen), 64'd0);
    drain();

    // Randomized traffic with occasional mid-run resets.
    for (int k = 0; k < 3000; k++) begin
      rand_inputs((k < 1500) ? 35 : 10);
      reset = ($urandom_range(0, 999) < 3);
      tick();
      reset = 0;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
